reg0_uart_tx: RTL and testbench
===============================

Name: reg0_uart_tx

Overview:
- Downstream consumer of the CPU's reg0/reg0_wr output port.
- Each reg0_wr pulse captures the reg0 byte into a small FIFO.
- Bytes are drained over a UART transmitter (8N1, LSB first) so program output can be read on a host terminal.
- Decouples the CPU's 4-cycle instruction rate from the slow serial line; overflow is flagged, never stalls the CPU.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- reg0  input  8  byte from CPU, valid when reg0_wr=1.
- reg0_wr  input  1  single-cycle write strobe from CPU.
- uart_tx  output  1  serial line; idle high.
- busy  output  1  FIFO non-empty or frame in progress.
- overflow  output  1  sticky: a write was dropped because FIFO full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: uart_tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, bit counters=0.
- Reset mid-frame: line returns high immediately (async); FIFO contents are discarded; the partial frame is abandoned.
- Push: on a rising edge with reg0_wr=1, reg0 is written to the FIFO tail.
- Full + write with no pop in the same cycle: byte dropped, overflow<=1, held until rst.
- Full + write with a pop in the same cycle: write accepted, count unchanged.
- Empty + write: byte enters the FIFO; a pop cannot occur in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: uart_tx=1. If FIFO non-empty, pop the head into an 8-bit shift register, clear the bit timer, go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; after bit 7, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: reg0_wr sampled at edge N with FSM idle and FIFO empty -> pop at edge N+1 -> uart_tx low from edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- uart_tx is driven from a register (glitch-free); no combinational path from inputs to uart_tx.
- busy = (state != IDLE) | (fifo_count != 0), registered or combinational from registered state.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count distinguishes full from empty.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - UART_DATA_BITS=8 constant;
  - default CLKS_PER_BIT constant.
- Sub-module byte_fifo (params DEPTH, WIDTH=8):
  - ports clk, rst, push, din, pop, dout, count, full, empty;
  - show-ahead dout, synchronous push/pop, async reset of pointers.
- The top level holds the overflow flag, the TX FSM, the bit timer and the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: reg0=8'hA5 pulse at edge N -> uart_tx low from N+1 for 4 cycles; then bits 1,0,1,0,0,1,0,1 (4 cycles each); high stop 4 cycles; busy drops at N+41.
- Back-to-back: writes 8'h01, 8'h02 four cycles apart -> two contiguous 40-cycle frames with no idle gap; overflow stays 0.
- Overflow: 6 writes (8'h10..8'h15) every 4 cycles -> 8'h10 starts transmitting. Then:
  - 8'h11..8'h14 fill the FIFO;
  - 8'h15 is dropped, overflow=1 and stays 1 through transmission of 5 frames;
  - host sees 10,11,12,13,14.
- Simultaneous full+pop: FIFO full, write issued on the cycle the FSM pops at the end of STOP -> write accepted, fifo_count stays 4, no overflow.
- Reset mid-frame: assert rst during DATA bit 3 of 8'hFF -> uart_tx=1 asynchronously, fifo_count=0, busy=0. After release, the line stays high until the next write.
- Idle line: no writes for 100 cycles after reset -> uart_tx constantly 1, busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the reg0 UART transmitter slice: the transmitter
//   state encoding, the number of data bits per frame and the default bit
//   period for a 27 MHz clock at 115200 baud.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Transmitter frame phases. IDLE holds the line high between frames.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 8N1 framing: eight data bits, no parity, one stop bit.
    localparam int UART_DATA_BITS = 8;

    // 27 MHz / 115200 baud, rounded to the nearest whole clock count.
    localparam int DEFAULT_CLKS_PER_BIT = 234;

endpackage : uart_pkg

// File: rtl/reg0_uart_tx_if.sv
// -----------------------------------------------------------------------------
// reg0_uart_tx_if
//   CPU output-port write channel: the reg0 byte and its single-cycle write
//   strobe. The CPU side uses the master modport, the transmitter the slave.
//
//   reg0     [7:0]  byte presented by the CPU, valid while reg0_wr is high
//   reg0_wr         one-cycle write strobe
// -----------------------------------------------------------------------------
interface reg0_uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] reg0;
    logic                      reg0_wr;

    modport master (output reg0, output reg0_wr);
    modport slave  (input  reg0, input  reg0_wr);

endinterface : reg0_uart_tx_if

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Small synchronous FIFO with show-ahead output: dout always presents the
//   head entry, and pop simply advances past it on the clock edge.
//
//   Parameters
//     DEPTH  number of entries; power of two, >= 2
//     WIDTH  entry width in bits
//
//   Ports
//     clk    system clock
//     rst    asynchronous reset, active-high (pointers and count only)
//     push   write din at the tail on this edge
//     din    data to write
//     pop    drop the head entry on this edge
//     dout   head entry (undefined while empty)
//     count  current occupancy, 0..DEPTH
//     full   count == DEPTH
//     empty  count == 0
//
//   A push while full is only taken when a pop happens on the same edge, so
//   the occupancy stays at DEPTH. A pop while empty is ignored.
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; only pointers and count
    // need a defined value, and a reset on the array would stop it mapping
    // onto RAM and add a large reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of the
    // order the simulator evaluates the always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : byte_fifo

// File: rtl/reg0_uart_tx.sv
// -----------------------------------------------------------------------------
// reg0_uart_tx
//   Captures every byte the CPU writes to its reg0 output port into a small
//   FIFO and drains the FIFO over an 8N1, LSB-first UART transmitter so
//   program output can be watched on a host terminal. The CPU is never
//   stalled: a write that finds the FIFO full is dropped and flagged.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit; must be >= 2
//     FIFO_DEPTH    byte FIFO entries; power of two, >= 2
//
//   Ports
//     clk         system clock
//     rst         asynchronous reset, active-high
//     cpu         reg0 / reg0_wr write channel (slave side)
//     uart_tx     serial line, registered, idles high
//     busy        FIFO non-empty or a frame in progress
//     overflow    sticky until rst: a write was dropped because FIFO full
//     fifo_count  current FIFO occupancy
//
//   Timing: a write sampled on edge N with the transmitter idle and the FIFO
//   empty is popped on edge N+1, which is also the edge that drives the start
//   bit. A frame is exactly 10*CLKS_PER_BIT cycles, and queued bytes follow
//   each other with no idle gap between the stop bit and the next start bit.
// -----------------------------------------------------------------------------
module reg0_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    reg0_uart_tx_if.slave                 cpu,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Bit timer runs 0..CLKS_PER_BIT-1; bit index runs 0..UART_DATA_BITS-1.
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [TW-1:0]             bit_timer;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_done;
    logic                      pop;
    logic                      drop;

    // -------------------------------------------------------------------------
    // Byte queue between the CPU and the serial line
    // -------------------------------------------------------------------------
    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu.reg0_wr),
        .din   (cpu.reg0),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (bit_timer == BIT_LAST);

    // The transmitter takes a new byte either from idle or at the last cycle
    // of a stop bit, which is what makes back-to-back frames gapless.
    // NOTE: pop and drop get a default before any condition so that no path
    // through the block leaves them unassigned, which would infer a latch.
    always_comb begin
        pop  = 1'b0;
        drop = 1'b0;
        if (!fifo_empty) begin
            pop = (state == IDLE) || ((state == STOP) && bit_done);
        end
        // A write into a full FIFO survives only if a pop frees a slot on
        // the same edge.
        drop = cpu.reg0_wr && fifo_full && !pop;
    end

    // Either the shift register is mid-frame or bytes are still queued.
    assign busy = (state != IDLE) || (fifo_count != '0);

    // -------------------------------------------------------------------------
    // Sticky overflow flag, cleared only by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM. uart_tx is loaded with the level of the phase being
    // entered on the same edge as the state change, so the line is a plain
    // register output with no combinational path from the inputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        bit_timer <= '0;
                        uart_tx   <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        uart_tx   <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (bit_idx == IDX_LAST) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // shift_reg[1] becomes shift_reg[0] on this edge,
                            // so it is the next bit to put on the line.
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            uart_tx   <= shift_reg[1];
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (pop) begin
                            shift_reg <= fifo_dout;
                            uart_tx   <= 1'b0;
                            state     <= START;
                        end else begin
                            uart_tx <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end

                default: begin
                    bit_timer <= '0;
                    uart_tx   <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : reg0_uart_tx

// File: tb/tb_reg0_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_reg0_uart_tx
//   Directed bench for reg0_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   Expected serial waveforms are built from the byte value: 4 cycles low,
//   the eight data bits LSB first at 4 cycles each, then 4 cycles high.
// -----------------------------------------------------------------------------
module tb_reg0_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg0_uart_tx_if cpu_if ();

    reg0_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_if),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write strobe; the byte is sampled on the next rising edge.
    task automatic send(input logic [7:0] b);
        cpu_if.reg0    = b;
        cpu_if.reg0_wr = 1'b1;
        step();
        cpu_if.reg0_wr = 1'b0;
    endtask

    // Called just after the edge that should drive the start bit; checks
    // every cycle of the 40-cycle frame and returns just after the edge
    // following the last stop-bit cycle.
    task automatic frame_check(input logic [7:0] b);
        for (int j = 0; j < 10 * CPB; j++) begin
            logic exp_bit;
            if (j < CPB)          exp_bit = 1'b0;
            else if (j < 9 * CPB) exp_bit = b[(j - CPB) / CPB];
            else                  exp_bit = 1'b1;
            check($sformatf("frame_%02h_cyc%0d", b, j), 32'(uart_tx), 32'(exp_bit));
            step();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_if.reg0    = 8'h00;
        cpu_if.reg0_wr = 1'b0;

        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        #1;
        check("rst_uart_tx",    32'(uart_tx),    32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        step();
        step();
        rst = 1'b0;

        // ---------------- single byte A5 ----------------
        send(8'hA5);                       // sampled at edge N
        check("a5_latency_line",  32'(uart_tx),    32'd1);
        check("a5_latency_count", 32'(fifo_count), 32'd1);
        check("a5_latency_busy",  32'(busy),       32'd1);
        step();                            // edge N+1: pop, start bit
        check("a5_popped_count",  32'(fifo_count), 32'd0);
        check("a5_busy_in_frame", 32'(busy),       32'd1);
        frame_check(8'hA5);                // now at edge N+41
        check("a5_end_busy",  32'(busy),    32'd0);
        check("a5_end_line",  32'(uart_tx), 32'd1);

        // ---------------- back-to-back 01, 02 ----------------
        send(8'h01);
        fork
            begin
                repeat (3) step();
                send(8'h02);
            end
            begin
                step();
                frame_check(8'h01);
                frame_check(8'h02);
            end
        join
        check("b2b_end_busy",     32'(busy),     32'd0);
        check("b2b_end_overflow", 32'(overflow), 32'd0);

        // ---------------- overflow: 10..15 ----------------
        send(8'h10);
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    repeat (3) step();
                    send(8'(8'h10 + k));
                    if (k == 4) begin
                        check("ovf_full_count",    32'(fifo_count), 32'd4);
                        check("ovf_not_yet",       32'(overflow),   32'd0);
                    end
                end
                check("ovf_flag_set",   32'(overflow),   32'd1);
                check("ovf_count_held", 32'(fifo_count), 32'd4);
            end
            begin
                step();
                for (int k = 0; k < 5; k++) begin
                    frame_check(8'(8'h10 + k));
                    check($sformatf("ovf_sticky_%0d", k), 32'(overflow), 32'd1);
                end
            end
        join
        check("ovf_end_busy",  32'(busy),       32'd0);
        check("ovf_end_count", 32'(fifo_count), 32'd0);
        apply_reset();
        check("ovf_cleared_by_rst", 32'(overflow), 32'd0);

        // ---------------- full FIFO + pop on same edge ----------------
        send(8'h20);                       // edge N
        fork
            begin
                for (int k = 1; k <= 4; k++) send(8'(8'h20 + k));  // N+1..N+4
                repeat (36) step();        // just after edge N+40
                check("fp_full_before", 32'(fifo_count), 32'd4);
                send(8'h25);               // sampled at edge N+41 with the pop
                check("fp_count_after", 32'(fifo_count), 32'd4);
                check("fp_no_overflow", 32'(overflow),   32'd0);
            end
            begin
                step();
                for (int k = 0; k < 6; k++) frame_check(8'(8'h20 + k));
            end
        join
        check("fp_end_busy",     32'(busy),     32'd0);
        check("fp_end_overflow", 32'(overflow), 32'd0);

        // ---------------- reset mid-frame ----------------
        send(8'hFF);                       // edge N
        send(8'hEE);                       // edge N+1 (FF popped, EE queued)
        check("mid_queued", 32'(fifo_count), 32'd1);
        repeat (17) step();                // inside DATA bit 3
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;                     // between clock edges
        #1;
        check("mid_rst_line",  32'(uart_tx),    32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        step();
        step();
        rst = 1'b0;

        // ---------------- idle line after reset ----------------
        for (int i = 0; i < 100; i++) begin
            check($sformatf("idle_line_%0d", i), 32'(uart_tx), 32'd1);
            check($sformatf("idle_busy_%0d", i), 32'(busy),    32'd0);
            step();
        end
        check("idle_count", 32'(fifo_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg0_uart_tx
